// File: rtl/turn_controller_if.sv
// Player/data-path handshake bundle for the Chicken Cha-Cha-Cha turn controller.
interface turn_controller_if;
   logic       start;
   logic       flip_btn;
   logic [3:0] tile_sel;
   logic       go;
   logic       W;
   logic       A;
   logic       B;
   logic       statecombo_next_turn;
   logic       reveal;
   logic [3:0] reveal_tile;
   logic       game_over;
   logic [2:0] state_dbg;

   // Drives player/data-path inputs, observes controller outputs.
   modport master (
      output start, flip_btn, tile_sel, go, W,
      input  A, B, statecombo_next_turn, reveal, reveal_tile, game_over, state_dbg
   );

   // The controller itself.
   modport slave (
      input  start, flip_btn, tile_sel, go, W,
      output A, B, statecombo_next_turn, reveal, reveal_tile, game_over, state_dbg
   );
endinterface

// File: rtl/turn_controller.sv
// Game-flow FSM: flip -> compare (A) -> reveal -> move/win-check (B) or turn pass.
module turn_controller #(
   parameter int unsigned CHECK_LAT     = 2,
   parameter int unsigned REVEAL_CYCLES = 50000000,
   parameter int unsigned WIN_LAT       = 2,
   parameter int unsigned TURN_TIMEOUT  = 500000000
) (
   input logic                clk,
   input logic                rst,
   turn_controller_if.slave   bus
);

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_WAIT_FLIP = 3'd1,
      ST_CHECK     = 3'd2,
      ST_REVEAL    = 3'd3,
      ST_MOVE      = 3'd4,
      ST_WIN_CHK   = 3'd5,
      ST_NEXT      = 3'd6,
      ST_OVER      = 3'd7
   } state_t;

   // One phase counter is shared by CHECK, REVEAL and WIN_CHK, so size it for the longest.
   localparam int unsigned PH_MAX = (CHECK_LAT > REVEAL_CYCLES) ?
                                    ((CHECK_LAT > WIN_LAT) ? CHECK_LAT : WIN_LAT) :
                                    ((REVEAL_CYCLES > WIN_LAT) ? REVEAL_CYCLES : WIN_LAT);
   localparam int unsigned PH_W   = (PH_MAX > 1) ? $clog2(PH_MAX) : 1;
   localparam int unsigned TURN_W = (TURN_TIMEOUT > 1) ? $clog2(TURN_TIMEOUT) : 1;

   localparam logic [PH_W-1:0]   CHECK_LAST  = PH_W'(CHECK_LAT - 1);
   localparam logic [PH_W-1:0]   REVEAL_LAST = PH_W'(REVEAL_CYCLES - 1);
   localparam logic [PH_W-1:0]   WIN_LAST    = PH_W'(WIN_LAT - 1);
   localparam logic [TURN_W-1:0] TURN_LAST   = TURN_W'(TURN_TIMEOUT - 1);
   localparam bit                TIMEOUT_EN  = (TURN_TIMEOUT != 0);

   state_t              state;
   logic [PH_W-1:0]     phase_cnt;
   logic [TURN_W-1:0]   turn_cnt;
   logic                flip_q;
   logic                go_q;
   logic                a_q;
   logic                b_q;
   logic                next_turn_q;
   logic                reveal_q;
   logic                game_over_q;
   logic [3:0]          reveal_tile_q;

   logic flip_rise;
   logic timeout_hit;

   assign flip_rise   = bus.flip_btn & ~flip_q;
   assign timeout_hit = TIMEOUT_EN && (turn_cnt == TURN_LAST);

   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= ST_IDLE;
         phase_cnt     <= '0;
         turn_cnt      <= '0;
         flip_q        <= 1'b0;
         go_q          <= 1'b0;
         a_q           <= 1'b0;
         b_q           <= 1'b0;
         next_turn_q   <= 1'b0;
         reveal_q      <= 1'b0;
         game_over_q   <= 1'b0;
         reveal_tile_q <= '0;
      end else begin
         flip_q      <= bus.flip_btn;
         a_q         <= 1'b0;
         b_q         <= 1'b0;
         next_turn_q <= 1'b0;

         case (state)
            ST_IDLE: begin
               if (bus.start) begin
                  state    <= ST_WAIT_FLIP;
                  turn_cnt <= '0;
               end
            end

            // A flip on the timeout cycle takes priority over passing the turn.
            ST_WAIT_FLIP: begin
               if (flip_rise) begin
                  reveal_tile_q <= bus.tile_sel;
                  state         <= ST_CHECK;
                  phase_cnt     <= '0;
                  a_q           <= 1'b1;
               end else if (timeout_hit) begin
                  state       <= ST_NEXT;
                  next_turn_q <= 1'b1;
               end else begin
                  turn_cnt <= turn_cnt + TURN_W'(1);
               end
            end

            ST_CHECK: begin
               if (phase_cnt == CHECK_LAST) begin
                  go_q      <= bus.go;
                  state     <= ST_REVEAL;
                  phase_cnt <= '0;
                  reveal_q  <= 1'b1;
               end else begin
                  phase_cnt <= phase_cnt + PH_W'(1);
               end
            end

            ST_REVEAL: begin
               if (phase_cnt == REVEAL_LAST) begin
                  reveal_q <= 1'b0;
                  if (go_q) begin
                     state <= ST_MOVE;
                     b_q   <= 1'b1;
                  end else begin
                     state       <= ST_NEXT;
                     next_turn_q <= 1'b1;
                  end
               end else begin
                  phase_cnt <= phase_cnt + PH_W'(1);
               end
            end

            ST_MOVE: begin
               state     <= ST_WIN_CHK;
               phase_cnt <= '0;
            end

            // Without a win the same player keeps the turn.
            ST_WIN_CHK: begin
               if (phase_cnt == WIN_LAST) begin
                  if (bus.W) begin
                     state       <= ST_OVER;
                     game_over_q <= 1'b1;
                  end else begin
                     state    <= ST_WAIT_FLIP;
                     turn_cnt <= '0;
                  end
               end else begin
                  phase_cnt <= phase_cnt + PH_W'(1);
               end
            end

            ST_NEXT: begin
               state    <= ST_WAIT_FLIP;
               turn_cnt <= '0;
            end

            ST_OVER: begin
               if (bus.start) begin
                  state       <= ST_IDLE;
                  game_over_q <= 1'b0;
               end
            end

            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

   assign bus.A                    = a_q;
   assign bus.B                    = b_q;
   assign bus.statecombo_next_turn = next_turn_q;
   assign bus.reveal               = reveal_q;
   assign bus.reveal_tile          = reveal_tile_q;
   assign bus.game_over            = game_over_q;
   assign bus.state_dbg            = state;

endmodule

// File: tb/tb_turn_controller.sv
// Self-checking bench: randomized turns checked against a timeline model of each turn.
module tb_turn_controller;

   localparam int CL = 2;
   localparam int RC = 4;
   localparam int WL = 2;
   localparam int TO = 20;

   localparam int S_IDLE   = 0;
   localparam int S_WAIT   = 1;
   localparam int S_CHECK  = 2;
   localparam int S_REVEAL = 3;
   localparam int S_MOVE   = 4;
   localparam int S_WIN    = 5;
   localparam int S_NEXT   = 6;
   localparam int S_OVER   = 7;

   logic clk;
   logic rst;
   turn_controller_if bif();

   turn_controller #(
      .CHECK_LAT(CL), .REVEAL_CYCLES(RC), .WIN_LAT(WL), .TURN_TIMEOUT(TO)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bif)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int         checks   = 0;
   int         failures = 0;
   int         cyc      = 0;
   int         wf_age   = 0;
   int         a_seen   = 0;
   logic [3:0] m_tile   = 4'h0;

   task automatic chk(input string tag, input logic [3:0] got, input logic [3:0] exp);
      checks++;
      assert (got === exp) else begin
         failures++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   // Compare every output of the current cycle against the expected frame.
   task automatic expect_frame(input string tag, input int st, input bit a, input bit b,
                               input bit nt, input bit rev, input bit over);
      if (bif.A === 1'b1) a_seen++;
      chk($sformatf("c%0d %s state", cyc, tag), 4'(bif.state_dbg), 4'(st));
      chk($sformatf("c%0d %s A", cyc, tag), 4'(bif.A), 4'(a));
      chk($sformatf("c%0d %s B", cyc, tag), 4'(bif.B), 4'(b));
      chk($sformatf("c%0d %s next_turn", cyc, tag), 4'(bif.statecombo_next_turn), 4'(nt));
      chk($sformatf("c%0d %s reveal", cyc, tag), 4'(bif.reveal), 4'(rev));
      chk($sformatf("c%0d %s reveal_tile", cyc, tag), bif.reveal_tile, m_tile);
      chk($sformatf("c%0d %s game_over", cyc, tag), 4'(bif.game_over), 4'(over));
   endtask

   task automatic noise();
      bif.tile_sel = 4'($urandom);
      bif.go       = 1'($urandom);
      bif.W        = 1'($urandom);
   endtask

   // n cycles inside the waiting phase; the turn passes after TO idle cycles.
   task automatic idle_wait(input int n, input bit btn);
      for (int i = 0; i < n; i++) begin
         if (wf_age == TO) expect_frame("timeout", S_NEXT, 0, 0, 1, 0, 0);
         else              expect_frame("wait", S_WAIT, 0, 0, 0, 0, 0);
         bif.flip_btn = btn;
         noise();
         tick();
         wf_age = (wf_age == TO) ? 0 : wf_age + 1;
      end
   endtask

   task automatic idle_state(input int n);
      for (int i = 0; i < n; i++) begin
         expect_frame("idle", S_IDLE, 0, 0, 0, 0, 0);
         bif.start    = 1'b0;
         bif.flip_btn = 1'($urandom);
         noise();
         tick();
      end
      bif.flip_btn = 1'b0;
   endtask

   // One flip and its full consequence, expressed as offsets from the flip cycle.
   task automatic turn(input int delay, input logic [3:0] tile, input bit go_v, input bit w_v,
                       input bit hold, input int rst_at, output bit won);
      int st;
      bit a, b, nt, rev;
      int w_off;
      int seq_len;
      won = 1'b0;
      idle_wait(delay, 1'b0);
      while (wf_age == TO) idle_wait(1, 1'b0);
      expect_frame("flip", S_WAIT, 0, 0, 0, 0, 0);
      noise();
      bif.flip_btn = 1'b1;
      bif.tile_sel = tile;
      tick();
      m_tile  = tile;
      w_off   = CL + RC + 1 + WL;
      seq_len = go_v ? w_off : CL + RC + 1;
      for (int o = 1; o <= seq_len; o++) begin
         a = 0; b = 0; nt = 0; rev = 0;
         if (o <= CL) begin
            st = S_CHECK; a = (o == 1);
         end else if (o <= CL + RC) begin
            st = S_REVEAL; rev = 1;
         end else if (o == CL + RC + 1) begin
            if (go_v) begin st = S_MOVE; b = 1; end
            else      begin st = S_NEXT; nt = 1; end
         end else begin
            st = S_WIN;
         end
         expect_frame("seq", st, a, b, nt, rev, 0);
         bif.flip_btn = hold ? 1'b1 : ((o == seq_len) ? 1'b0 : 1'($urandom));
         bif.tile_sel = 4'($urandom);
         bif.go       = (o == CL) ? go_v : 1'($urandom);
         bif.W        = (o == w_off) ? w_v : 1'($urandom);
         if (o == rst_at) begin
            rst = 1'b1;
            tick();
            rst    = 1'b0;
            m_tile = 4'h0;
            return;
         end
         tick();
      end
      won    = go_v && w_v;
      wf_age = 0;
   endtask

   // Linger in OVER with ignored flips, then start twice: OVER -> IDLE -> WAIT_FLIP.
   task automatic over_phase(input int n);
      for (int i = 0; i < n; i++) begin
         expect_frame("over", S_OVER, 0, 0, 0, 0, 1);
         bif.start    = 1'b0;
         bif.flip_btn = 1'($urandom);
         noise();
         tick();
      end
      expect_frame("over_start", S_OVER, 0, 0, 0, 0, 1);
      bif.start    = 1'b1;
      bif.flip_btn = 1'b0;
      tick();
      expect_frame("restart_idle", S_IDLE, 0, 0, 0, 0, 0);
      tick();
      bif.start = 1'b0;
      wf_age    = 0;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish at cycle %0d", cyc);
      $fatal(1, "watchdog expired");
   end

   initial begin
      bit won;
      rst          = 1'b1;
      bif.start    = 1'b0;
      bif.flip_btn = 1'b0;
      bif.tile_sel = 4'h0;
      bif.go       = 1'b0;
      bif.W        = 1'b0;
      tick();
      tick();
      expect_frame("reset", S_IDLE, 0, 0, 0, 0, 0);
      rst = 1'b0;
      idle_state(10);

      expect_frame("start", S_IDLE, 0, 0, 0, 0, 0);
      bif.start = 1'b1;
      tick();
      bif.start = 1'b0;
      wf_age    = 0;

      turn(3, 4'h9, 1'b1, 1'b0, 1'b0, 0, won);
      turn(2, 4'h9, 1'b0, 1'b0, 1'b0, 0, won);
      idle_wait(25, 1'b0);

      a_seen = 0;
      turn(0, 4'h5, 1'b0, 1'b0, 1'b1, 0, won);
      idle_wait(22, 1'b1);
      chk("hold_single_A", 4'(a_seen), 4'd1);
      idle_wait(1, 1'b0);

      turn((wf_age < TO) ? (TO - 1 - wf_age) : TO, 4'hC, 1'b0, 1'b0, 1'b0, 0, won);

      turn(1, 4'h3, 1'b1, 1'b1, 1'b0, 0, won);
      chk("win_reached", 4'(won), 4'd1);
      over_phase(5);

      for (int t = 0; t < 30; t++) begin
         turn($urandom_range(0, 24), 4'($urandom), 1'($urandom),
              ($urandom_range(0, 5) == 0), 1'b0, 0, won);
         if (won) over_phase($urandom_range(1, 4));
      end

      turn(0, 4'h7, 1'b1, 1'b0, 1'b0, CL + 2, won);
      idle_state(8);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
